// File: rtl/uart_store_arbiter.sv
// Merges UART transmit-register stores from both issue lanes into one ordered
// byte stream, buffered in a FIFO and drained under a ready handshake.
module uart_store_arbiter #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] UART_ADDR = 32'h0000_F000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       st0_valid,
    input  logic [31:0]                st0_addr,
    input  logic [7:0]                 st0_data,
    input  logic                       st1_valid,
    input  logic [31:0]                st1_addr,
    input  logic [7:0]                 st1_data,
    output logic                       stall,
    input  logic                       uart_ready,
    output logic [8:0]                 uart_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          hit0;
    logic          hit1;
    logic [1:0]    need;
    logic [CW-1:0] free;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_slot1;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        return p + PW'(n);
    endfunction

    // Request decode and admission
    always_comb begin
        hit0  = st0_valid && (st0_addr == UART_ADDR);
        hit1  = st1_valid && (st1_addr == UART_ADDR);
        need  = {1'b0, hit0} + {1'b0, hit1};
        // Only the registered occupancy counts; a pop this cycle frees nothing yet.
        free  = CW'(DEPTH) - count;
        stall = !reset && (CW'(need) > free);
        push  = !reset && !stall && (need != 2'd0);
        pop   = !reset && (count != '0) && uart_ready;
        // Lane 1 lands behind lane 0 when both hit, otherwise takes the head slot.
        wr_slot1 = hit0 ? ptr_add(wr_ptr, 2'd1) : wr_ptr;
    end

    // Storage: data path, never reset
    always_ff @(posedge clock) begin
        if (push) begin
            if (hit0) mem[wr_ptr]   <= st0_data;
            if (hit1) mem[wr_slot1] <= st1_data;
        end
    end

    // Control state
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_add(wr_ptr, need);
            if (pop)  rd_ptr <= ptr_add(rd_ptr, 2'd1);
            count <= count + (push ? CW'(need) : CW'(0)) - CW'(pop);
        end
    end

    // Output is derived purely from registered state; nothing is forwarded.
    assign uart_out = (count != '0) ? {1'b1, mem[rd_ptr]} : 9'h000;

endmodule

// File: tb/tb_uart_store_arbiter.sv
// Directed bench for uart_store_arbiter with a small queue model for the
// streaming/wrap section.
module tb_uart_store_arbiter;

    localparam logic [31:0] UA = 32'h0000_F000;

    logic        clock = 1'b0;
    logic        reset;
    logic        st0_valid, st1_valid;
    logic [31:0] st0_addr, st1_addr;
    logic [7:0]  st0_data, st1_data;
    logic        stall;
    logic        uart_ready;
    logic [8:0]  uart_out;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    uart_store_arbiter #(.DEPTH(8), .UART_ADDR(UA)) dut (
        .clock(clock), .reset(reset),
        .st0_valid(st0_valid), .st0_addr(st0_addr), .st0_data(st0_data),
        .st1_valid(st1_valid), .st1_addr(st1_addr), .st1_data(st1_data),
        .stall(stall), .uart_ready(uart_ready),
        .uart_out(uart_out), .count(count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lanes(input logic v0, input logic [31:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [31:0] a1, input logic [7:0] d1);
        st0_valid = v0; st0_addr = a0; st0_data = d0;
        st1_valid = v1; st1_addr = a1; st1_data = d1;
    endtask

    task automatic idle();
        lanes(1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00);
    endtask

    logic [7:0] q[$];
    int         sent;
    bit         dual_next;
    int         n;
    bit         exp_stall;
    bit         do_pop;
    int         cyc;
    logic [8:0] exp_out;

    initial begin
        reset = 1'b1; uart_ready = 1'b0;
        idle();
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_out", 32'(uart_out), 32'h000);
        chk("reset_count", 32'(count), 0);
        chk("reset_stall", 32'(stall), 0);

        // Single store into empty FIFO
        uart_ready = 1'b1;
        lanes(1'b1, UA, 8'h41, 1'b0, 32'h0, 8'h00);
        #1;
        chk("single_stall", 32'(stall), 0);
        step(); idle();
        chk("single_out1", 32'(uart_out), 32'h141);
        chk("single_cnt1", 32'(count), 1);
        step();
        chk("single_out2", 32'(uart_out), 32'h000);
        chk("single_cnt2", 32'(count), 0);

        // Dual hit in one cycle
        lanes(1'b1, UA, 8'h48, 1'b1, UA, 8'h69);
        step(); idle();
        chk("dual_out1", 32'(uart_out), 32'h148);
        chk("dual_cnt1", 32'(count), 2);
        step();
        chk("dual_out2", 32'(uart_out), 32'h169);
        chk("dual_cnt2", 32'(count), 1);
        step();
        chk("dual_out3", 32'(uart_out), 32'h000);
        chk("dual_cnt3", 32'(count), 0);

        // Address filter
        uart_ready = 1'b0;
        lanes(1'b1, 32'h0000_F004, 8'h55, 1'b1, UA, 8'h21);
        step(); idle();
        chk("filt_cnt", 32'(count), 1);
        chk("filt_out", 32'(uart_out), 32'h121);
        uart_ready = 1'b1;
        step();
        chk("filt_drain", 32'(count), 0);

        // Fill and stall
        uart_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            lanes(1'b1, UA, 8'(i), 1'b0, 32'h0, 8'h00);
            step();
        end
        idle();
        chk("fill_cnt7", 32'(count), 7);
        lanes(1'b1, UA, 8'hD0, 1'b1, UA, 8'hD1);
        #1;
        chk("fill_dual_stall", 32'(stall), 1);
        step();
        chk("fill_cnt_hold", 32'(count), 7);
        lanes(1'b1, UA, 8'h07, 1'b0, 32'h0, 8'h00);
        #1;
        chk("fill_last_stall", 32'(stall), 0);
        step();
        chk("fill_cnt8", 32'(count), 8);
        lanes(1'b0, 32'h0, 8'h00, 1'b1, UA, 8'hEE);
        #1;
        chk("full_stall", 32'(stall), 1);
        step(); idle();
        chk("full_cnt", 32'(count), 8);
        uart_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_drain", 32'(uart_out), 32'h100 | i);
            step();
        end
        chk("fill_empty_out", 32'(uart_out), 32'h000);
        chk("fill_empty_cnt", 32'(count), 0);

        // Wrap with concurrent push/pop against a queue model
        sent = 0; dual_next = 1'b0; cyc = 0;
        while (sent < 20 && cyc < 200) begin
            n = (dual_next && sent <= 18) ? 2 : 1;
            if (n == 2) lanes(1'b1, UA, 8'(8'h80 + sent), 1'b1, UA, 8'(8'h81 + sent));
            else        lanes(1'b1, UA, 8'(8'h80 + sent), 1'b0, 32'h0, 8'h00);
            uart_ready = cyc[0];
            #1;
            exp_stall = (n > 8 - q.size());
            exp_out   = (q.size() != 0) ? {1'b1, q[0]} : 9'h000;
            chk("wrap_stall", 32'(stall), 32'(exp_stall));
            chk("wrap_cnt", 32'(count), q.size());
            chk("wrap_out", 32'(uart_out), 32'(exp_out));
            do_pop = (q.size() != 0) && uart_ready;
            @(posedge clock);
            if (do_pop) void'(q.pop_front());
            if (!exp_stall) begin
                q.push_back(8'(8'h80 + sent));
                if (n == 2) q.push_back(8'(8'h81 + sent));
                sent += n;
                dual_next = !dual_next;
            end
            #1;
            cyc++;
        end
        chk("wrap_all_sent", 32'(sent), 20);
        idle();
        uart_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            #1;
            chk("wrap_drain", 32'(uart_out), 32'({1'b1, q[0]}));
            step();
            void'(q.pop_front());
            cyc++;
        end
        chk("wrap_final_cnt", 32'(count), 0);

        // Reset mid-operation
        uart_ready = 1'b0;
        lanes(1'b1, UA, 8'hA1, 1'b0, 32'h0, 8'h00); step();
        lanes(1'b1, UA, 8'hA2, 1'b0, 32'h0, 8'h00); step();
        lanes(1'b1, UA, 8'hA3, 1'b0, 32'h0, 8'h00); step();
        chk("rst_pre_cnt", 32'(count), 3);
        reset = 1'b1;
        lanes(1'b1, UA, 8'hEE, 1'b0, 32'h0, 8'h00);
        #1;
        chk("rst_stall_during", 32'(stall), 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        chk("rst_out", 32'(uart_out), 32'h000);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_stall", 32'(stall), 0);
        uart_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_ghost", 32'(uart_out), 32'h000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
